counter_bank: RTL and testbench
===============================

# counter_bank

Multi-channel up/down counter bank, a parametrised successor to the single-channel unit-step counter. It provides `NUM_CH` independent counters with per-channel programmable step, wrap or saturate overflow mode, sticky or pulsed overflow flags, and a registered compare-match pulse. It serves event and performance counting, timeout generation and credit tracking in peripheral and interconnect subsystems.

## Interface
- `NUM_CH`, 4, number of independent channels (≥1)
- `WIDTH`, 8, counter width in bits (≥2)
- `MODE`, `counter_bank_pkg::CNT_WRAP`, overflow mode, either `CNT_WRAP` or `CNT_SAT`, applied to all channels
- `STICKY_OVERFLOW`, 1'b0, 1: overflow flag holds until clear/load; 0: one-cycle pulse
- `clk_i` in 1: clock, all state on rising edge
- `rst_ni` in 1: asynchronous active-low reset
- `clear_i` in NUM_CH: per-channel synchronous clear
- `en_i` in NUM_CH: per-channel count enable
- `load_i` in NUM_CH: per-channel load of `d_i`
- `down_i` in NUM_CH: per-channel direction, 1 = down
- `delta_i` in NUM_CH×WIDTH: per-channel step, sampled each enabled cycle
- `d_i` in NUM_CH×WIDTH: per-channel load value
- `cmp_i` in NUM_CH×WIDTH: per-channel compare value
- `q_o` out NUM_CH×WIDTH: counter values
- `overflow_o` out NUM_CH: per-channel overflow/underflow flag
- `match_o` out NUM_CH: per-channel compare-match pulse
- `any_overflow_o` out 1: OR of `overflow_o`

## Operation
- Each channel updates independently, with priority per cycle: `clear_i` > `load_i` > `en_i` > hold.
- Clear: `q`←0, `overflow`←0, `match`←0.
- Load: `q`←`d_i`, `overflow`←0, `match`←0.
- Count arithmetic is done at WIDTH+1 bits:
  - up: `s = {0,q} + {0,delta}`, event when `s[WIDTH]` = 1
  - down: `s = {0,q} − {0,delta}`, event when `s[WIDTH]` = 1 (borrow)
- In `CNT_WRAP`, `q`←`s[WIDTH-1:0]` when an event occurs.
- In `CNT_SAT`, an up event sets `q`←all-ones and a down event sets `q`←0. A saturated counter still flags an event when pushed further.
- A step of 0 with `en_i` high holds `q`, raises no event, and can still produce a match.
- Overflow flag, `STICKY_OVERFLOW=0`: `overflow`←event on every cycle, so it pulses for one cycle after each event.
- Overflow flag, `STICKY_OVERFLOW=1`: `overflow`←`overflow | event`, cleared only by clear, load or reset.
- Match: `match`←(`en_i` & next `q` == `cmp_i`), registered. It is low on any cycle without `en_i` and on clear/load cycles.
- `down_i` and `delta_i` are ignored when `en_i`=0.

## Timing
- Reset sets every `q_o` to 0 and every `overflow_o`, `match_o` and `any_overflow_o` to 0, asynchronously.
- Latency: every output is registered. An action in cycle N is visible after edge N. `any_overflow_o` is combinational from the `overflow` registers and adds no cycle.
- Reset asserted mid-operation forces the reset values immediately. The first update after deassertion occurs on the first rising edge with `rst_ni`=1.
- Simultaneous `clear_i`, `load_i` and `en_i`: the priority above applies and no event is counted.
- Channels never interact. Simultaneous activity on all channels is legal.

## Structure
- `counter_bank_pkg` holds:
  - `cnt_mode_e` with `CNT_WRAP` and `CNT_SAT`
  - the helper function `cnt_step(q, delta, down)` returning next value and event bit at WIDTH+1 bits
- The natural sub-module is `counter_bank_ch`, one channel with the registers, arithmetic, mode and flag logic. `counter_bank` instantiates it with a generate loop and ORs the overflow flags.
- Arrays are packed `[NUM_CH-1:0][WIDTH-1:0]`.

## Test plan
- Reset and priority, ch0: reset, then `load_i`=1 with `d_i`=0x10 → `q_o[0]`=0x10. Next cycle assert `clear_i`, `load_i` and `en_i` together → `q_o[0]`=0 and `overflow_o[0]`=0.
- Wrap up, `WIDTH`=8, `MODE`=WRAP, non-sticky: load 0xFE, `delta`=3, up → `q`=0x01 and `overflow` high for exactly one cycle. With `en_i` held, next `q`=0x04 and `overflow` low.
- Saturate down, `MODE`=SAT, sticky: load 0x02, `delta`=5, down → `q`=0x00 and `overflow`=1, staying at 0x00 and 1 over 3 more enabled cycles. `clear_i` drops `overflow` to 0.
- Compare match: load 0x00, `cmp`=0x06, `delta`=2, up → `match_o` pulses exactly on the cycle `q_o` becomes 0x06, and not on 0x02, 0x04 or 0x08. Loading 0x06 gives no match.
- Channel independence, `NUM_CH`=4: ch1 up by 1, ch2 down by 4 from 0x03, ch3 idle → ch2 overflows and sets `any_overflow_o`. ch1 and ch3 values and flags are unaffected.
- Async reset mid-count: assert `rst_ni`=0 between edges during counting → all outputs drop to 0 before the next edge, and counting resumes from 0 after release.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types and the step arithmetic helper for the counter bank.
// Arithmetic is done on a wide word; callers keep bits [WIDTH:0].
package counter_bank_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W-1:0] cnt_word_t;
  typedef logic [CNT_MAX_W:0]   cnt_sum_t;

  // Bit WIDTH of the result is carry (up) or borrow (down).
  function automatic cnt_sum_t cnt_step(
    input cnt_word_t q,
    input cnt_word_t delta,
    input logic      down
  );
    cnt_sum_t s;
    if (down) begin
      s = {1'b0, q} - {1'b0, delta};
    end else begin
      s = {1'b0, q} + {1'b0, delta};
    end
    return s;
  endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: value, overflow flag and compare-match registers.
// Priority per cycle is clear, then load, then count, then hold.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter cnt_mode_e   MODE   = CNT_WRAP,
  parameter bit          STICKY = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o,
  output logic             match_o
);

  logic [WIDTH-1:0] r_q;
  logic             r_ov;
  logic             r_match;

  cnt_sum_t         w_full;
  logic             w_event;
  logic             w_unused_hi;
  logic [WIDTH-1:0] w_next_q;
  logic             w_hit;

  assign w_full = cnt_step(cnt_word_t'(r_q),
                           cnt_word_t'(delta_i),
                           down_i);

  assign w_event     = w_full[WIDTH];
  assign w_unused_hi = ^w_full[CNT_MAX_W:WIDTH+1];

  // Saturation pins to the rail the step pushed past.
  always_comb begin
    w_next_q = w_full[WIDTH-1:0];
    if (w_event && (MODE == CNT_SAT)) begin
      w_next_q = down_i ? '0 : '1;
    end
  end

  assign w_hit = (w_next_q == cmp_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q     <= '0;
      r_ov    <= 1'b0;
      r_match <= 1'b0;
    end else if (clear_i) begin
      r_q     <= '0;
      r_ov    <= 1'b0;
      r_match <= 1'b0;
    end else if (load_i) begin
      r_q     <= d_i;
      r_ov    <= 1'b0;
      r_match <= 1'b0;
    end else if (en_i) begin
      r_q     <= w_next_q;
      r_ov    <= STICKY ? (r_ov | w_event) : w_event;
      r_match <= w_hit;
    end else begin
      r_ov    <= STICKY ? r_ov : 1'b0;
      r_match <= 1'b0;
    end
  end

  assign q_o        = r_q;
  assign overflow_o = r_ov;
  assign match_o    = r_match;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with a shared overflow summary.
// Mode and flag behaviour are common to all channels.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned WIDTH           = 8,
  parameter cnt_mode_e   MODE            = CNT_WRAP,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CH-1:0]             clear_i,
  input  logic [NUM_CH-1:0]             en_i,
  input  logic [NUM_CH-1:0]             load_i,
  input  logic [NUM_CH-1:0]             down_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  delta_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  d_i,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  cmp_i,
  output logic [NUM_CH-1:0][WIDTH-1:0]  q_o,
  output logic [NUM_CH-1:0]             overflow_o,
  output logic [NUM_CH-1:0]             match_o,
  output logic                          any_overflow_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_bank_ch #(
      .WIDTH  (WIDTH),
      .MODE   (MODE),
      .STICKY (STICKY_OVERFLOW)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i[g]),
      .en_i       (en_i[g]),
      .load_i     (load_i[g]),
      .down_i     (down_i[g]),
      .delta_i    (delta_i[g]),
      .d_i        (d_i[g]),
      .cmp_i      (cmp_i[g]),
      .q_o        (q_o[g]),
      .overflow_o (overflow_o[g]),
      .match_o    (match_o[g])
    );
  end

  assign any_overflow_o = |overflow_o;

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: a wrap/pulse bank and a sat/sticky bank share
// stimulus; expected results are queued per cycle and popped after edges.
module tb_counter_bank;
  import counter_bank_pkg::*;

  logic            clk;
  logic            rst_n;
  logic [3:0]      clear, en, load, down;
  logic [3:0][7:0] delta, d, cmp;

  logic [3:0][7:0] q_w, q_s;
  logic [3:0]      ov_w, ov_s, m_w, m_s;
  logic            any_w, any_s;

  typedef struct {
    logic       inst;
    int         ch;
    logic [7:0] q;
    logic       ov;
    logic       m;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] aq;
  logic       ao, am;
  int         n_checks = 0;
  int         n_errors = 0;

  counter_bank #(
    .NUM_CH(4), .WIDTH(8), .MODE(CNT_WRAP), .STICKY_OVERFLOW(1'b0)
  ) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en),
    .load_i(load), .down_i(down), .delta_i(delta), .d_i(d),
    .cmp_i(cmp), .q_o(q_w), .overflow_o(ov_w), .match_o(m_w),
    .any_overflow_o(any_w)
  );

  counter_bank #(
    .NUM_CH(4), .WIDTH(8), .MODE(CNT_SAT), .STICKY_OVERFLOW(1'b1)
  ) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en),
    .load_i(load), .down_i(down), .delta_i(delta), .d_i(d),
    .cmp_i(cmp), .q_o(q_s), .overflow_o(ov_s), .match_o(m_s),
    .any_overflow_o(any_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    clear = '0; en = '0; load = '0; down = '0;
    delta = '0; d = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    cmp = '0;
    #12;
    n_checks++;
    if ({q_w, ov_w, m_w, any_w} !== '0) begin
      n_errors++;
      $display("FAIL reset_wrap: got q=%h ov=%b m=%b any=%b, expected all zero",
               q_w, ov_w, m_w, any_w);
    end
    n_checks++;
    if ({q_s, ov_s, m_s, any_s} !== '0) begin
      n_errors++;
      $display("FAIL reset_sat: got q=%h ov=%b m=%b any=%b, expected all zero",
               q_s, ov_s, m_s, any_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    logic [7:0] xq[2];
    string      nm[2];
    xq = '{8'h10, 8'h00};
    nm = '{"prio_load", "prio_clear"};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle();
      d[0] = 8'h10; delta[0] = 8'h03; cmp[0] = 8'h00;
      load[0] = 1'b1;
      if (k == 1) begin
        clear[0] = 1'b1; en[0] = 1'b1;
      end
      sb.push_back(exp_t'{1'b0, 0, xq[k], 1'b0, 1'b0, nm[k]});
      sb.push_back(exp_t'{1'b1, 0, xq[k], 1'b0, 1'b0, nm[k]});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        aq = e.inst ? q_s[e.ch]  : q_w[e.ch];
        ao = e.inst ? ov_s[e.ch] : ov_w[e.ch];
        am = e.inst ? m_s[e.ch]  : m_w[e.ch];
        n_checks++;
        if ({aq, ao, am} !== {e.q, e.ov, e.m}) begin
          n_errors++;
          $display("FAIL %s inst%0d: got q=%h ov=%b m=%b, expected q=%h ov=%b m=%b",
                   e.name, e.inst, aq, ao, am, e.q, e.ov, e.m);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [7:0] wq[4], sq[4];
    logic       wo[4], so[4];
    wq = '{8'hFE, 8'h01, 8'h04, 8'h04};
    wo = '{1'b0, 1'b1, 1'b0, 1'b0};
    sq = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
    so = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      d[0] = 8'hFE; delta[0] = 8'h03; cmp[0] = 8'h55;
      load[0] = (k == 0);
      en[0]   = (k == 1) || (k == 2);
      sb.push_back(exp_t'{1'b0, 0, wq[k], wo[k], 1'b0, "wrap_up"});
      sb.push_back(exp_t'{1'b1, 0, sq[k], so[k], 1'b0, "sat_up"});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        aq = e.inst ? q_s[e.ch]  : q_w[e.ch];
        ao = e.inst ? ov_s[e.ch] : ov_w[e.ch];
        am = e.inst ? m_s[e.ch]  : m_w[e.ch];
        n_checks++;
        if ({aq, ao, am} !== {e.q, e.ov, e.m}) begin
          n_errors++;
          $display("FAIL %s[%0d] inst%0d: got q=%h ov=%b m=%b, expected q=%h ov=%b m=%b",
                   e.name, k, e.inst, aq, ao, am, e.q, e.ov, e.m);
        end
      end
    end
  endtask

  task automatic test_sat_down();
    logic [7:0] sq[6];
    logic       so[6];
    sq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    so = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle();
      d[0] = 8'h02; delta[0] = 8'h05; down[0] = 1'b1;
      cmp[0] = 8'h77;
      load[0]  = (k == 0);
      en[0]    = (k >= 1) && (k <= 4);
      clear[0] = (k == 5);
      sb.push_back(exp_t'{1'b1, 0, sq[k], so[k], 1'b0, "sat_down"});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({q_s[0], ov_s[0], any_s} !== {e.q, e.ov, e.ov}) begin
          n_errors++;
          $display("FAIL %s[%0d]: got q=%h ov=%b any=%b, expected q=%h ov=%b any=%b",
                   e.name, k, q_s[0], ov_s[0], any_s, e.q, e.ov, e.ov);
        end
      end
    end
  endtask

  task automatic test_match();
    logic [7:0] xq[9];
    logic       xm[9];
    xq = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h08, 8'h06, 8'h06, 8'h06};
    xm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      idle();
      cmp[0]   = 8'h06;
      d[0]     = (k == 0) ? 8'h00 : 8'h06;
      delta[0] = (k == 7) ? 8'h00 : 8'h02;
      load[0]  = (k == 0) || (k == 6);
      en[0]    = ((k >= 1) && (k <= 4)) || (k == 7);
      sb.push_back(exp_t'{1'b0, 0, xq[k], 1'b0, xm[k], "match"});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({q_w[0], ov_w[0], m_w[0]} !== {e.q, e.ov, e.m}) begin
          n_errors++;
          $display("FAIL %s[%0d]: got q=%h ov=%b m=%b, expected q=%h ov=%b m=%b",
                   e.name, k, q_w[0], ov_w[0], m_w[0], e.q, e.ov, e.m);
        end
      end
    end
  endtask

  task automatic test_independence();
    logic xany_w[3], xany_s[3];
    xany_w = '{1'b0, 1'b1, 1'b0};
    xany_s = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      cmp = {8'hAA, 8'hAA, 8'hAA, 8'h06};
      d   = {8'h30, 8'h03, 8'h10, 8'h00};
      delta[1] = 8'h01;
      delta[2] = 8'h04; down[2] = 1'b1;
      load = (k == 0) ? 4'b1110 : 4'b0000;
      en   = (k == 1) ? 4'b0110 : 4'b0000;
      case (k)
        0: begin
          sb.push_back(exp_t'{1'b0, 1, 8'h10, 1'b0, 1'b0, "ind_c1"});
          sb.push_back(exp_t'{1'b0, 2, 8'h03, 1'b0, 1'b0, "ind_c2"});
          sb.push_back(exp_t'{1'b0, 3, 8'h30, 1'b0, 1'b0, "ind_c3"});
        end
        1: begin
          sb.push_back(exp_t'{1'b0, 1, 8'h11, 1'b0, 1'b0, "ind_c1"});
          sb.push_back(exp_t'{1'b0, 2, 8'hFF, 1'b1, 1'b0, "ind_c2"});
          sb.push_back(exp_t'{1'b0, 3, 8'h30, 1'b0, 1'b0, "ind_c3"});
          sb.push_back(exp_t'{1'b1, 2, 8'h00, 1'b1, 1'b0, "ind_sat_c2"});
        end
        default: begin
          sb.push_back(exp_t'{1'b0, 2, 8'hFF, 1'b0, 1'b0, "ind_c2"});
          sb.push_back(exp_t'{1'b1, 2, 8'h00, 1'b1, 1'b0, "ind_sat_c2"});
          sb.push_back(exp_t'{1'b1, 1, 8'h11, 1'b0, 1'b0, "ind_sat_c1"});
        end
      endcase
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        aq = e.inst ? q_s[e.ch]  : q_w[e.ch];
        ao = e.inst ? ov_s[e.ch] : ov_w[e.ch];
        am = e.inst ? m_s[e.ch]  : m_w[e.ch];
        n_checks++;
        if ({aq, ao, am} !== {e.q, e.ov, e.m}) begin
          n_errors++;
          $display("FAIL %s[%0d] inst%0d: got q=%h ov=%b m=%b, expected q=%h ov=%b m=%b",
                   e.name, k, e.inst, aq, ao, am, e.q, e.ov, e.m);
        end
      end
      n_checks++;
      if ({any_w, any_s} !== {xany_w[k], xany_s[k]}) begin
        n_errors++;
        $display("FAIL ind_any[%0d]: got any_w=%b any_s=%b, expected any_w=%b any_s=%b",
                 k, any_w, any_s, xany_w[k], xany_s[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] xq[5];
    xq = '{8'h40, 8'h41, 8'h42, 8'h01, 8'h02};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle();
      cmp = '0;
      d[0] = 8'h40; delta[0] = 8'h01;
      load[0] = (k == 0);
      en[0]   = (k != 0);
      if (k == 3) rst_n = 1'b1;
      sb.push_back(exp_t'{1'b0, 0, xq[k], 1'b0, 1'b0, "async_cnt"});
      @(posedge clk); #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({q_w[0], ov_w[0], m_w[0]} !== {e.q, e.ov, e.m}) begin
          n_errors++;
          $display("FAIL %s[%0d]: got q=%h ov=%b m=%b, expected q=%h ov=%b m=%b",
                   e.name, k, q_w[0], ov_w[0], m_w[0], e.q, e.ov, e.m);
        end
      end
      if (k == 2) begin
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q_w, ov_w, m_w, any_w, q_s, ov_s, m_s, any_s} !== '0) begin
          n_errors++;
          $display("FAIL async_reset: got q_w=%h q_s=%h ov_w=%b ov_s=%b, expected zeros",
                   q_w, q_s, ov_w, ov_s);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cmp = '0;
    test_reset();
    test_priority();
    test_wrap_up();
    test_sat_down();
    test_match();
    test_independence();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
